// File: rtl/nvram_uploader_if.sv
// HPS ioctl upload bus between the HPS bridge (master) and the NVRAM uploader (slave).
interface nvram_uploader_if;
  logic        ioctl_upload;
  logic        ioctl_rd;
  logic [7:0]  ioctl_index;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic        ioctl_upload_req;

  modport master (
    output ioctl_upload, ioctl_rd, ioctl_index, ioctl_addr,
    input  ioctl_din, ioctl_wait, ioctl_upload_req
  );

  modport slave (
    input  ioctl_upload, ioctl_rd, ioctl_index, ioctl_addr,
    output ioctl_din, ioctl_wait, ioctl_upload_req
  );
endinterface

// File: rtl/nvram_uploader.sv
// Streams the NVRAM shadow RAM to the HPS byte by byte and requests uploads on save.
// Define NVRAM_AUTOSAVE_EN to add the autosave timer that requests an upload after writes settle.
module nvram_uploader #(
  parameter int          AW      = 11,
  parameter logic [7:0]  INDEX   = 8'd4,
  parameter logic [23:0] TIMEOUT = 24'd14318180
) (
  input  logic              clk_sys,
  input  logic              reset,
  nvram_uploader_if.slave   ioctl,
  input  logic              save_req,
  input  logic              nv_we,
  output logic [AW-1:0]     mem_addr,
  input  logic [15:0]       mem_q,
  output logic              busy
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ARMED   = 3'd1;
  localparam logic [2:0] S_ADDR    = 3'd2;
  localparam logic [2:0] S_READ    = 3'd3;
  localparam logic [2:0] S_PRESENT = 3'd4;

  localparam logic [24:0] LAST_ADDR = 25'((1 << (AW + 1)) - 1);

  logic [2:0]    r_state;
  logic [24:0]   r_addr;
  logic [AW-1:0] r_mem_addr;
  logic [15:0]   r_q;
  logic [7:0]    r_din;
  logic          r_wait;
  logic          r_upload_req;
  logic          r_dirty;
  logic          r_pending;
  logic          r_save_d;

  logic w_go_idle;
  logic w_present;
  logic w_oob;
  logic w_last;
  logic w_save_rise;
  logic w_timer_req;
  logic w_req;
  logic w_fire;

  assign w_go_idle   = (r_state != S_IDLE) && !ioctl.ioctl_upload;
  assign w_present   = (r_state == S_PRESENT) && !w_go_idle;
  assign w_oob       = (r_addr >> (AW + 1)) != 25'd0;
  assign w_last      = (r_addr == LAST_ADDR);
  assign w_save_rise = save_req && !r_save_d;
  assign w_req       = w_save_rise || w_timer_req;
  // A pending request goes out on the edge that enters IDLE so the pulse lands in the first IDLE cycle.
  assign w_fire      = ((r_state == S_IDLE) || w_go_idle) && (w_req || r_pending);

`ifdef NVRAM_AUTOSAVE_EN
  logic [23:0] r_timer;

  // The request fires on the 1->0 step only, so the timer idling at 0 never re-triggers.
  assign w_timer_req = r_dirty && (r_state == S_IDLE) && !nv_we && (r_timer == 24'd1);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_timer <= 24'd0;
    end else if (nv_we) begin
      r_timer <= TIMEOUT;
    end else if (r_dirty && (r_state == S_IDLE) && (r_timer != 24'd0)) begin
      r_timer <= r_timer - 24'd1;
    end
  end
`else
  logic w_unused_timeout;

  assign w_timer_req      = 1'b0;
  assign w_unused_timeout = ^TIMEOUT;
`endif

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_addr       <= 25'd0;
      r_mem_addr   <= '0;
      r_q          <= 16'd0;
      r_din        <= 8'h00;
      r_wait       <= 1'b0;
      r_upload_req <= 1'b0;
      r_dirty      <= 1'b0;
      r_pending    <= 1'b0;
      r_save_d     <= 1'b0;
    end else begin
      r_save_d     <= save_req;
      r_upload_req <= w_fire;
      r_pending    <= !w_fire && (r_pending || w_req);

      if (nv_we) begin
        r_dirty <= 1'b1;
      end else if (w_present && w_last) begin
        r_dirty <= 1'b0;
      end

      if (w_go_idle) begin
        r_state <= S_IDLE;
        r_wait  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (ioctl.ioctl_upload && (ioctl.ioctl_index == INDEX)) begin
              r_state <= S_ARMED;
            end
          end
          S_ARMED: begin
            if (ioctl.ioctl_rd) begin
              r_addr     <= ioctl.ioctl_addr;
              r_mem_addr <= ioctl.ioctl_addr[AW:1];
              r_wait     <= 1'b1;
              r_state    <= S_ADDR;
            end
          end
          S_ADDR: begin
            r_state <= S_READ;
          end
          S_READ: begin
            r_q     <= mem_q;
            r_state <= S_PRESENT;
          end
          S_PRESENT: begin
            // Big-endian words: even byte address is the high byte.
            r_din   <= w_oob ? 8'hFF : (r_addr[0] ? r_q[7:0] : r_q[15:8]);
            r_wait  <= 1'b0;
            r_state <= S_ARMED;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign ioctl.ioctl_din        = r_din;
  assign ioctl.ioctl_wait       = r_wait;
  assign ioctl.ioctl_upload_req = r_upload_req;
  assign mem_addr               = r_mem_addr;
  assign busy                   = (r_state != S_IDLE);

endmodule

// File: tb/tb_nvram_uploader.sv
// Directed self-checking bench for nvram_uploader at AW=2 (8-byte RAM), TIMEOUT=10.
// Covers fetch latency, byte order, out-of-range reads, dirty tracking, aborts, reset and save requests.
module tb_nvram_uploader;

  logic        clk;
  logic        reset;
  logic        saveReq;
  logic        nvWe;
  logic [1:0]  memAddr;
  logic [15:0] memQ;
  logic        busy;

  logic [15:0] ram [4];

  int nCompared;
  int nMismatched;

  nvram_uploader_if bus ();

  nvram_uploader #(
    .AW      (2),
    .INDEX   (8'd4),
    .TIMEOUT (24'd10)
  ) dut (
    .clk_sys  (clk),
    .reset    (reset),
    .ioctl    (bus),
    .save_req (saveReq),
    .nv_we    (nvWe),
    .mem_addr (memAddr),
    .mem_q    (memQ),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read RAM model: data appears the cycle after the address.
  always @(posedge clk) memQ <= ram[memAddr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic open_session();
    bus.ioctl_upload = 1'b1;
    bus.ioctl_index  = 8'd4;
    tick();
  endtask

  task automatic do_fetch(input logic [24:0] a, input logic weAtPresent,
                          output logic [3:0] waits, output logic [7:0] din);
    bus.ioctl_addr = a;
    bus.ioctl_rd   = 1'b1;
    tick();
    bus.ioctl_rd = 1'b0;
    waits[0] = bus.ioctl_wait;
    tick();
    waits[1] = bus.ioctl_wait;
    tick();
    waits[2] = bus.ioctl_wait;
    if (weAtPresent) nvWe = 1'b1;
    tick();
    nvWe = 1'b0;
    waits[3] = bus.ioctl_wait;
    din = bus.ioctl_din;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    nCompared += 6;
    if (bus.ioctl_din !== 8'h00) begin nMismatched++; $display("[TB] FAIL reset_din: got %h expected 00", bus.ioctl_din); end
    if (bus.ioctl_wait !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_wait: got %b expected 0", bus.ioctl_wait); end
    if (bus.ioctl_upload_req !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_req: got %b expected 0", bus.ioctl_upload_req); end
    if (memAddr !== 2'd0) begin nMismatched++; $display("[TB] FAIL reset_mem_addr: got %h expected 0", memAddr); end
    if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    if (dut.r_dirty !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_dirty: got %b expected 0", dut.r_dirty); end
    reset = 1'b0;
  endtask

  task automatic test_fetch();
    logic [3:0]  waits;
    logic [7:0]  din;
    logic [24:0] addrs [4];
    logic [7:0]  exps [4];
    addrs = '{25'd0, 25'd1, 25'd3, 25'd6};
    exps  = '{8'hA5, 8'h5A, 8'h34, 8'hC0};
    do_reset();
    open_session();
    nCompared++;
    if (busy !== 1'b1) begin nMismatched++; $display("[TB] FAIL armed_busy: got %b expected 1", busy); end
    for (int i = 0; i < 4; i++) begin
      do_fetch(addrs[i], 1'b0, waits, din);
      nCompared += 2;
      if (waits !== 4'b0111) begin nMismatched++; $display("[TB] FAIL fetch_wait addr %0d: got %b expected 0111", addrs[i], waits); end
      if (din !== exps[i]) begin nMismatched++; $display("[TB] FAIL fetch_din addr %0d: got %h expected %h", addrs[i], din, exps[i]); end
    end
  endtask

  task automatic test_out_of_range();
    logic [3:0] waits;
    logic [7:0] din;
    do_fetch(25'd8, 1'b0, waits, din);
    nCompared += 2;
    if (waits !== 4'b0111) begin nMismatched++; $display("[TB] FAIL oob_wait: got %b expected 0111", waits); end
    if (din !== 8'hFF) begin nMismatched++; $display("[TB] FAIL oob_din addr 8: got %h expected ff", din); end
    do_fetch(25'h1FFFFFF, 1'b0, waits, din);
    nCompared++;
    if (din !== 8'hFF) begin nMismatched++; $display("[TB] FAIL oob_din addr max: got %h expected ff", din); end
  endtask

  task automatic test_ignored();
    bus.ioctl_upload = 1'b0;
    tick();
    bus.ioctl_addr = 25'd2;
    bus.ioctl_rd   = 1'b1;
    tick();
    bus.ioctl_rd = 1'b0;
    tick();
    nCompared += 2;
    if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL rd_idle_busy: got %b expected 0", busy); end
    if (bus.ioctl_wait !== 1'b0) begin nMismatched++; $display("[TB] FAIL rd_idle_wait: got %b expected 0", bus.ioctl_wait); end
    bus.ioctl_upload = 1'b1;
    bus.ioctl_index  = 8'd3;
    tick();
    tick();
    nCompared++;
    if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL wrong_index_busy: got %b expected 0", busy); end
    bus.ioctl_upload = 1'b0;
    tick();
  endtask

  task automatic test_dirty();
    logic [3:0] waits;
    logic [7:0] din;
    logic [7:0] bytes [8];
    bytes = '{8'hA5, 8'h5A, 8'h12, 8'h34, 8'hBE, 8'hEF, 8'hC0, 8'hDE};
    do_reset();
    nvWe = 1'b1;
    tick();
    nvWe = 1'b0;
    nCompared++;
    if (dut.r_dirty !== 1'b1) begin nMismatched++; $display("[TB] FAIL dirty_set: got %b expected 1", dut.r_dirty); end
    open_session();
    for (int i = 0; i < 8; i++) begin
      do_fetch(25'(i), 1'b0, waits, din);
      nCompared++;
      if (din !== bytes[i]) begin nMismatched++; $display("[TB] FAIL session_din byte %0d: got %h expected %h", i, din, bytes[i]); end
      if (i == 6) begin
        nCompared++;
        if (dut.r_dirty !== 1'b1) begin nMismatched++; $display("[TB] FAIL dirty_before_last: got %b expected 1", dut.r_dirty); end
      end
    end
    nCompared++;
    if (dut.r_dirty !== 1'b0) begin nMismatched++; $display("[TB] FAIL dirty_cleared: got %b expected 0", dut.r_dirty); end
    nvWe = 1'b1;
    tick();
    nvWe = 1'b0;
    nCompared++;
    if (dut.r_dirty !== 1'b1) begin nMismatched++; $display("[TB] FAIL dirty_set_in_session: got %b expected 1", dut.r_dirty); end
    for (int i = 0; i < 8; i++) begin
      do_fetch(25'(i), (i == 7), waits, din);
    end
    nCompared += 2;
    if (din !== 8'hDE) begin nMismatched++; $display("[TB] FAIL last_byte_din: got %h expected de", din); end
    if (dut.r_dirty !== 1'b1) begin nMismatched++; $display("[TB] FAIL dirty_kept_by_we: got %b expected 1", dut.r_dirty); end
    bus.ioctl_upload = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    logic [3:0] waits;
    logic [7:0] din;
    do_reset();
    nvWe = 1'b1;
    tick();
    nvWe = 1'b0;
    open_session();
    do_fetch(25'd0, 1'b0, waits, din);
    bus.ioctl_addr = 25'd1;
    bus.ioctl_rd   = 1'b1;
    tick();
    bus.ioctl_rd = 1'b0;
    tick();
    bus.ioctl_upload = 1'b0;
    tick();
    nCompared += 4;
    if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
    if (bus.ioctl_wait !== 1'b0) begin nMismatched++; $display("[TB] FAIL abort_wait: got %b expected 0", bus.ioctl_wait); end
    if (bus.ioctl_din !== 8'hA5) begin nMismatched++; $display("[TB] FAIL abort_din: got %h expected a5", bus.ioctl_din); end
    if (dut.r_dirty !== 1'b1) begin nMismatched++; $display("[TB] FAIL abort_dirty: got %b expected 1", dut.r_dirty); end
  endtask

  task automatic test_reset_mid_fetch();
    logic [3:0] waits;
    logic [7:0] din;
    int pulses;
    do_reset();
    open_session();
    do_fetch(25'd0, 1'b0, waits, din);
    bus.ioctl_addr = 25'd5;
    bus.ioctl_rd   = 1'b1;
    tick();
    bus.ioctl_rd = 1'b0;
    nCompared++;
    if (memAddr !== 2'd2) begin nMismatched++; $display("[TB] FAIL addr_mem_addr: got %h expected 2", memAddr); end
    reset   = 1'b1;
    nvWe    = 1'b1;
    saveReq = 1'b1;
    tick();
    reset            = 1'b0;
    nvWe             = 1'b0;
    saveReq          = 1'b0;
    bus.ioctl_upload = 1'b0;
    nCompared += 6;
    if (bus.ioctl_din !== 8'h00) begin nMismatched++; $display("[TB] FAIL rst_mid_din: got %h expected 00", bus.ioctl_din); end
    if (bus.ioctl_wait !== 1'b0) begin nMismatched++; $display("[TB] FAIL rst_mid_wait: got %b expected 0", bus.ioctl_wait); end
    if (bus.ioctl_upload_req !== 1'b0) begin nMismatched++; $display("[TB] FAIL rst_mid_req: got %b expected 0", bus.ioctl_upload_req); end
    if (memAddr !== 2'd0) begin nMismatched++; $display("[TB] FAIL rst_mid_mem_addr: got %h expected 0", memAddr); end
    if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL rst_mid_busy: got %b expected 0", busy); end
    if (dut.r_dirty !== 1'b0) begin nMismatched++; $display("[TB] FAIL rst_mid_dirty: got %b expected 0", dut.r_dirty); end
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.ioctl_upload_req === 1'b1) pulses++;
    end
    nCompared++;
    if (pulses !== 0) begin nMismatched++; $display("[TB] FAIL rst_mid_no_req: got %0d pulses expected 0", pulses); end
  endtask

  task automatic test_save_idle();
    int pulses;
    do_reset();
    saveReq = 1'b1;
    tick();
    nCompared++;
    if (bus.ioctl_upload_req !== 1'b1) begin nMismatched++; $display("[TB] FAIL save_idle_req: got %b expected 1", bus.ioctl_upload_req); end
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.ioctl_upload_req === 1'b1) pulses++;
    end
    saveReq = 1'b0;
    tick();
    nCompared++;
    if (pulses !== 0) begin nMismatched++; $display("[TB] FAIL save_idle_single: got %0d extra pulses expected 0", pulses); end
  endtask

  task automatic test_back_to_back();
    int pulses;
    do_reset();
    open_session();
    saveReq = 1'b1;
    tick();
    saveReq = 1'b0;
    tick();
    saveReq = 1'b1;
    tick();
    saveReq = 1'b0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.ioctl_upload_req === 1'b1) pulses++;
    end
    nCompared++;
    if (pulses !== 0) begin nMismatched++; $display("[TB] FAIL pending_while_busy: got %0d pulses expected 0", pulses); end
    bus.ioctl_upload = 1'b0;
    tick();
    nCompared += 2;
    if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL pending_idle_busy: got %b expected 0", busy); end
    if (bus.ioctl_upload_req !== 1'b1) begin nMismatched++; $display("[TB] FAIL pending_first_idle_req: got %b expected 1", bus.ioctl_upload_req); end
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.ioctl_upload_req === 1'b1) pulses++;
    end
    nCompared++;
    if (pulses !== 0) begin nMismatched++; $display("[TB] FAIL pending_merged: got %0d extra pulses expected 0", pulses); end
  endtask

  task automatic test_autosave();
    int pulses;
    int firstAt;
    do_reset();
    nvWe = 1'b1;
    pulses  = 0;
    firstAt = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      nvWe = 1'b0;
      if (bus.ioctl_upload_req === 1'b1) begin
        pulses++;
        if (firstAt < 0) firstAt = k;
      end
    end
`ifdef NVRAM_AUTOSAVE_EN
    nCompared += 2;
    if (firstAt !== 11) begin nMismatched++; $display("[TB] FAIL autosave_latency: got tick %0d expected 11", firstAt); end
    if (pulses !== 1) begin nMismatched++; $display("[TB] FAIL autosave_pulses: got %0d expected 1", pulses); end
`else
    nCompared++;
    if (pulses !== 0) begin nMismatched++; $display("[TB] FAIL no_autosave_pulses: got %0d expected 0 (first at %0d)", pulses, firstAt); end
`endif
  endtask

  initial begin
    ram[0] = 16'hA55A;
    ram[1] = 16'h1234;
    ram[2] = 16'hBEEF;
    ram[3] = 16'hC0DE;
    nCompared        = 0;
    nMismatched      = 0;
    reset            = 1'b1;
    saveReq          = 1'b0;
    nvWe             = 1'b0;
    bus.ioctl_upload = 1'b0;
    bus.ioctl_rd     = 1'b0;
    bus.ioctl_index  = 8'd0;
    bus.ioctl_addr   = 25'd0;

    test_reset();
    test_fetch();
    test_out_of_range();
    test_ignored();
    test_dirty();
    test_abort();
    test_reset_mid_fetch();
    test_save_idle();
    test_back_to_back();
    test_autosave();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/nvram_uploader.md
NVRAM_UPLOADER -- requirements
Module: nvram_uploader

Interface
REQ-001 The block SHALL have parameter AW, default 11, meaning the word-address width of the NVRAM shadow RAM, giving 2^(AW+1) bytes.
REQ-002 The block SHALL have parameter INDEX, default 8'd4, meaning the ioctl_index value that selects the NVRAM transfer.
REQ-003 The block SHALL have parameter TIMEOUT, default 24'd14318180, meaning the autosave delay in clk_sys cycles (about 1 s).
REQ-004 clk_sys  in  1  the single system clock; all logic SHALL be clocked on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 ioctl_upload  in  1  HPS upload session active.
REQ-007 ioctl_rd  in  1  HPS byte-read strobe, one cycle wide.
REQ-008 ioctl_index  in  8  selects the transfer target.
REQ-009 ioctl_addr  in  25  byte address of the requested byte.
REQ-010 ioctl_din  out  8  byte returned to the HPS.
REQ-011 ioctl_wait  out  1  high while the requested byte is not yet valid; HPS stalls.
REQ-012 ioctl_upload_req  out  1  one-cycle pulse asking the HPS to start an upload.
REQ-013 save_req  in  1  manual save request (OSD status bit, level).
REQ-014 nv_we  in  1  pulse, one cycle, when the game writes the NVRAM.
REQ-015 mem_addr  out  AW  word address to the RAM read port.
REQ-016 mem_q  in  16  RAM read data, valid one cycle after mem_addr is presented.
REQ-017 busy  out  1  high in any state other than IDLE.

Function
REQ-018 States SHALL be IDLE, ARMED, ADDR, READ, PRESENT.
REQ-019 IDLE->ARMED when ioctl_upload=1 and ioctl_index==INDEX; any state->IDLE on the cycle after ioctl_upload=0.
REQ-020 In ARMED, ioctl_rd=1 in cycle N SHALL latch ioctl_addr and move to ADDR; ioctl_wait SHALL be 1 from N+1 until it drops at N+4.
REQ-021 In ADDR (N+1), mem_addr SHALL be driven with the latched addr[AW:1]; in READ (N+2), mem_q SHALL be captured.
REQ-022 In PRESENT (N+3), ioctl_din SHALL be updated and the state SHALL return to ARMED; ioctl_din and ioctl_wait=0 SHALL be valid from N+4.
REQ-023 Byte order is big-endian: an even address SHALL return mem_q[15:8] and an odd address SHALL return mem_q[7:0].
REQ-024 An address at or above 2^(AW+1) SHALL return 8'hFF with identical latency.
REQ-025 ioctl_rd outside ARMED SHALL be ignored with no state change.
REQ-026 A dirty flag SHALL be set by nv_we, including during a session.
REQ-027 The dirty flag SHALL be cleared when the byte at address 2^(AW+1)-1 is presented, unless nv_we occurs in the same cycle, in which case dirty SHALL remain 1.
REQ-028 A session aborted before the last byte SHALL leave the dirty flag unchanged.
REQ-029 A rising edge of save_req while IDLE SHALL pulse ioctl_upload_req for one cycle.
REQ-030 A rising edge of save_req while not IDLE SHALL be held pending and issued on the first IDLE cycle.
REQ-031 At most one request SHALL be pending; further rising edges of save_req are merged into it.
REQ-032 An abort mid-fetch SHALL drop ioctl_wait to 0 on the next cycle.
REQ-033 An abort mid-fetch SHALL leave ioctl_din holding its last presented value.

Reset
REQ-034 Reset SHALL put the block in IDLE with ioctl_din=8'h00, ioctl_wait=0, ioctl_upload_req=0, mem_addr=0, busy=0, dirty=0, pending request cleared and timer=0.
REQ-035 Reset asserted mid-operation SHALL override all other events in the same cycle.

Configuration
REQ-036 The macro NVRAM_AUTOSAVE_EN SHALL compile the autosave timer in or out.
REQ-037 With NVRAM_AUTOSAVE_EN defined, a 24-bit timer SHALL reload to TIMEOUT on each nv_we and decrement while dirty=1 and the state is IDLE.
REQ-038 With NVRAM_AUTOSAVE_EN defined, the timer reaching 0 with dirty=1 SHALL raise a request exactly as a save_req edge does.
REQ-039 With NVRAM_AUTOSAVE_EN defined, the timer SHALL then hold at 0 until the next nv_we.
REQ-040 Without NVRAM_AUTOSAVE_EN, no timer SHALL exist and ioctl_upload_req SHALL be raised only by save_req.

Verification
REQ-041 RAM word0=16'hA55A; index 4, rd at addr 0 in cycle N then addr 1 -> ioctl_wait high N+1..N+3; ioctl_din=8'hA5, then 8'h5A.
REQ-042 AW=2; rd at addr 8 -> ioctl_din=8'hFF with the same 3-cycle wait.
REQ-043 nv_we, then a full session of 8 bytes at AW=2 -> dirty cleared; repeat with nv_we during the last PRESENT -> dirty stays 1.
REQ-044 ioctl_upload dropped during READ -> IDLE next cycle, ioctl_wait=0, dirty unchanged; reset during ADDR -> all outputs at reset values next cycle.
REQ-045 save_req rises while busy -> ioctl_upload_req pulses exactly once, on the first IDLE cycle.
REQ-046 NVRAM_AUTOSAVE_EN with TIMEOUT=10, one nv_we -> ioctl_upload_req pulses once, 10 cycles later, and no further pulse follows.
